// File: rtl/pipe_skid_pkg.sv
// Shared definitions for valid/ready pipeline-stage blocks.
package pipe_skid_pkg;

  // Occupancy states of a two-entry (main + skid) pipeline stage.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned PIPE_MAX_ENTRIES = 2;

  // Acceptance rule: a skid stage takes data until both slots are used,
  // a single-entry stage only when it is completely empty.
  function automatic logic pipe_can_accept(input pipe_state_e st, input logic skid);
    if (skid) begin
      return st != ST_FULL;
    end
    return st == ST_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Occupancy FSM of the skid register: produces handshake outputs and the
// load enables for the main and skid data registers.
module pipe_skid_ctrl
  import pipe_skid_pkg::*;
#(
  parameter int SKID = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic main_load,
  output logic main_sel_skid,
  output logic skid_load
);

  pipe_state_e state_q, state_d;
  logic        in_fire, out_fire;

  // Handshake outputs depend on the registered state only (plus reset),
  // so in_ready never has a combinational path from out_ready.
  always_comb begin
    in_ready  = !rst && pipe_can_accept(state_q, SKID != 0);
    out_valid = (state_q != ST_EMPTY);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
  end

  // Next-state and data-register load decisions; flush overrides everything
  // and leaves the data registers untouched.
  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d   = ST_BUSY;
            main_load = 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire && (SKID != 0)) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d       = ST_BUSY;
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State register; reset empties the stage immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with optional skid slot. out_data comes
// straight from the main register; the skid slot catches the word that
// arrives while the main one is stalled.
module pipe_skid_reg
  import pipe_skid_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               SKID        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_load, main_sel_skid, skid_load;

  pipe_skid_ctrl #(
    .SKID (SKID)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .out_ready     (out_ready),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .main_load     (main_load),
    .main_sel_skid (main_sel_skid),
    .skid_load     (skid_load)
  );

  // Main slot refills from the skid slot when draining FULL, otherwise from input.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (main_load) begin
      main_d = main_sel_skid ? skid_q : in_data;
    end
    if (skid_load) begin
      skid_d = in_data;
    end
  end

  // Data registers; they keep their last contents when nothing is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out_data = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and random checks of pipe_skid_reg in skid and single-entry modes.
module tb_pipe_skid_reg;

  localparam logic [7:0] RV = 8'h5A;

  logic clk, rst;
  logic iv1, ir1, ov1, or1, fl1;
  logic [7:0] id1, od1;
  logic iv0, ir0, ov0, or0, fl0;
  logic [7:0] id0, od0;

  int checks = 0;
  int errors = 0;

  pipe_skid_reg #(.WIDTH(8), .RESET_VALUE(RV), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
    .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1));

  pipe_skid_reg #(.WIDTH(8), .RESET_VALUE(RV), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(fl0), .in_valid(iv0), .in_ready(ir0),
    .in_data(id0), .out_valid(ov0), .out_ready(or0), .out_data(od0));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       erdy;
    logic       eov;
    logic [7:0] eod;
  } vec_t;

  vec_t tbl [17];
  logic [7:0] q1 [$];
  logic [7:0] q0 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy,
                              input logic fl, input logic erdy, input logic eov,
                              input logic [7:0] eod);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.erdy = erdy; v.eov = eov; v.eod = eod;
    return v;
  endfunction

  // Queue model step for one instance: check outputs against model, then update.
  task automatic sb_step(input int k, input logic ir, input logic ov, input logic [7:0] od,
                         input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    int sz;
    logic [7:0] front;
    sz = (k == 1) ? q1.size() : q0.size();
    front = 8'h00;
    if (sz > 0) front = (k == 1) ? q1[0] : q0[0];
    chk(k == 1 ? "rnd_ovalid_s1" : "rnd_ovalid_s0", {31'd0, ov}, {31'd0, sz > 0});
    if (k == 1) chk("rnd_irdy_s1", {31'd0, ir}, {31'd0, sz < 2});
    else        chk("rnd_irdy_s0", {31'd0, ir}, {31'd0, sz == 0});
    if (sz > 0) chk(k == 1 ? "rnd_data_s1" : "rnd_data_s0", {24'd0, od}, {24'd0, front});
    if (ov && ordy && sz > 0) begin
      if (k == 1) void'(q1.pop_front());
      else        void'(q0.pop_front());
    end
    if (fl) begin
      if (k == 1) q1.delete();
      else        q0.delete();
    end else if (iv && ir) begin
      if (k == 1) q1.push_back(id);
      else        q0.push_back(id);
    end
  endtask

  initial begin
    logic       hold1, hold0;
    logic [7:0] pod1, pod0;
    logic [7:0] nxt;

    rst = 1'b1;
    iv1 = 1'b0; id1 = 8'h00; or1 = 1'b0; fl1 = 1'b0;
    iv0 = 1'b0; id0 = 8'h00; or0 = 1'b0; fl0 = 1'b0;

    // Backpressure / flush table for the skid instance.
    tbl[0]  = mk(1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 1'b0, RV);
    tbl[1]  = mk(1'b1, 8'h0B, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0A);
    tbl[2]  = mk(1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0A);
    tbl[3]  = mk(1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0A);
    tbl[4]  = mk(1'b1, 8'h0C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0A);
    tbl[5]  = mk(1'b1, 8'h0C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0B);
    tbl[6]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0C);
    tbl[7]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0C);
    tbl[8]  = mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0C);
    tbl[9]  = mk(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11);
    tbl[10] = mk(1'b1, 8'h0D, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
    tbl[11] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
    tbl[12] = mk(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
    tbl[13] = mk(1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33);
    tbl[14] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33);
    tbl[15] = mk(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33);
    tbl[16] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55);

    // Reset state while rst is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irdy", {31'd0, ir1}, 32'd0);
    chk("rst_ovalid", {31'd0, ov1}, 32'd0);
    chk("rst_data", {24'd0, od1}, {24'd0, RV});
    chk("rst_irdy_s0", {31'd0, ir0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge clk);
      iv1 = tbl[i].iv; id1 = tbl[i].id; or1 = tbl[i].ordy; fl1 = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d_irdy", i), {31'd0, ir1}, {31'd0, tbl[i].erdy});
      chk($sformatf("tbl%0d_ovalid", i), {31'd0, ov1}, {31'd0, tbl[i].eov});
      chk($sformatf("tbl%0d_data", i), {24'd0, od1}, {24'd0, tbl[i].eod});
    end

    // Asynchronous reset in FULL: entries vanish without a clock edge.
    @(negedge clk);
    iv1 = 1'b1; id1 = 8'h66; or1 = 1'b0; fl1 = 1'b0;
    @(negedge clk);
    iv1 = 1'b0;
    #1;
    chk("full_irdy", {31'd0, ir1}, 32'd0);
    chk("full_data", {24'd0, od1}, 32'h55);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_ovalid", {31'd0, ov1}, 32'd0);
    chk("arst_data", {24'd0, od1}, {24'd0, RV});
    chk("arst_irdy", {31'd0, ir1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_irdy", {31'd0, ir1}, 32'd1);
    chk("post_rst_ovalid", {31'd0, ov1}, 32'd0);

    // Skid streaming: 0x01..0x10 back to back with out_ready high.
    for (int k = 0; k < 18; k++) begin
      if (k > 0) @(negedge clk);
      iv1 = (k < 16); id1 = 8'(k + 1); or1 = 1'b1;
      #1;
      chk($sformatf("strm%0d_irdy", k), {31'd0, ir1}, 32'd1);
      chk($sformatf("strm%0d_ovalid", k), {31'd0, ov1}, {31'd0, (k >= 1 && k <= 16)});
      if (k >= 1 && k <= 16) chk($sformatf("strm%0d_data", k), {24'd0, od1}, k);
    end
    iv1 = 1'b0;

    // Single-entry streaming: one transfer every second cycle.
    nxt = 8'h01;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      iv0 = 1'b1; id0 = nxt; or0 = 1'b1;
      #1;
      chk($sformatf("s0strm%0d_irdy", k), {31'd0, ir0}, {31'd0, (k % 2) == 0});
      chk($sformatf("s0strm%0d_ovalid", k), {31'd0, ov0}, {31'd0, (k % 2) == 1});
      if ((k % 2) == 1) chk($sformatf("s0strm%0d_data", k), {24'd0, od0}, (k + 1) / 2);
      chk($sformatf("s0strm%0d_excl", k), {31'd0, ir0 && ov0}, 32'd0);
      if (ir0) nxt = nxt + 8'h01;
    end

    // Single-entry backpressure holds data and refuses input.
    @(negedge clk);
    iv0 = 1'b1; id0 = 8'h77; or0 = 1'b0;
    #1;
    chk("s0bp_irdy0", {31'd0, ir0}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      id0 = 8'h78;
      #1;
      chk("s0bp_irdy", {31'd0, ir0}, 32'd0);
      chk("s0bp_data", {24'd0, od0}, 32'h77);
    end
    @(negedge clk);
    iv0 = 1'b0; or0 = 1'b1;
    @(negedge clk);
    #1;
    chk("s0bp_drain", {31'd0, ov0}, 32'd0);

    // Random valid/ready/flush on both instances against a queue model.
    hold1 = 1'b0; hold0 = 1'b0; pod1 = 8'h00; pod0 = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      iv1 = ($urandom_range(0, 9) < 7); id1 = 8'($urandom);
      or1 = ($urandom_range(0, 9) < 6); fl1 = ($urandom_range(0, 49) == 0);
      iv0 = ($urandom_range(0, 9) < 7); id0 = 8'($urandom);
      or0 = ($urandom_range(0, 9) < 6); fl0 = ($urandom_range(0, 49) == 0);
      #1;
      if (hold1) begin
        chk("stable_v_s1", {31'd0, ov1}, 32'd1);
        chk("stable_d_s1", {24'd0, od1}, {24'd0, pod1});
      end
      if (hold0) begin
        chk("stable_v_s0", {31'd0, ov0}, 32'd1);
        chk("stable_d_s0", {24'd0, od0}, {24'd0, pod0});
      end
      hold1 = ov1 && !or1 && !fl1; pod1 = od1;
      hold0 = ov0 && !or0 && !fl0; pod0 = od0;
      sb_step(1, ir1, ov1, od1, iv1, id1, or1, fl1);
      sb_step(0, ir0, ov0, od0, iv0, id0, or0, fl0);
    end

    @(negedge clk);
    iv1 = 1'b0; fl1 = 1'b0; iv0 = 1'b0; fl0 = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (>=1).
REQ-002 SHALL have parameter RESET_VALUE, default 0, WIDTH-bit reset value of both data registers.
REQ-003 SHALL have parameter SKID, default 1: 1 = full-throughput skid mode, 0 = half-throughput single-entry mode.
REQ-004 SHALL have ports: clk  in  1  sole clock, all state updates on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  synchronous discard of all held entries.
REQ-007 in_valid  in  1  upstream offers in_data.
REQ-008 in_ready  out  1  block can accept this cycle.
REQ-009 in_data  in  WIDTH  upstream payload.
REQ-010 out_valid  out  1  out_data holds a valid entry.
REQ-011 out_ready  in  1  downstream accepts this cycle.
REQ-012 out_data  out  WIDTH  payload of the oldest held entry.

Function
REQ-013 Input transfer (in_fire) SHALL occur when in_valid && in_ready at posedge; output transfer (out_fire) when out_valid && out_ready.
REQ-014 SHALL implement FSM states EMPTY (0 entries), BUSY (main full), FULL (main + skid full); FULL unreachable when SKID=0.
REQ-015 out_valid SHALL equal (state != EMPTY); out_data SHALL be driven directly from the main register (no combinational path from in_data).
REQ-016 SKID=1: in_ready SHALL equal (state != FULL) and SHALL NOT depend combinationally on out_ready.
REQ-017 SKID=0: in_ready SHALL equal (state == EMPTY).
REQ-018 EMPTY: in_fire -> BUSY, main <= in_data; else stay.
REQ-019 BUSY: in_fire && out_fire -> BUSY, main <= in_data; in_fire only -> FULL, skid <= in_data; out_fire only -> EMPTY; neither -> stay, main held.
REQ-020 FULL: out_fire -> BUSY, main <= skid; else stay; no input accepted.
REQ-021 Latency SHALL be 1 cycle: data accepted at edge N is on out_data with out_valid=1 after edge N when main was free.
REQ-022 Ordering SHALL be strict FIFO; no entry dropped or duplicated except by flush.
REQ-023 SKID=1 SHALL sustain one transfer per cycle with out_ready held high.
REQ-024 out_valid SHALL NOT deassert and out_data SHALL NOT change while out_valid && !out_ready (except flush/reset).
REQ-025 flush SHALL have highest priority: next state EMPTY, any in_fire in the same cycle is dropped, data registers hold their values.
REQ-026 out_data value while out_valid=0 SHALL be the last main-register content (don't-care for consumers).

Reset
REQ-027 While rst=1: state EMPTY, out_valid=0, main and skid = RESET_VALUE, in_ready=0.
REQ-028 First posedge after rst deasserts SHALL see in_ready=1; rst asserted mid-transfer SHALL discard all entries immediately, no clock needed.

Structure
REQ-029 State encodings (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) SHALL live in the shared pipeline definitions package/header, reused by other pipeline-stage blocks.
REQ-030 One sub-module is natural: pipe_skid_ctrl (FSM, in_ready/out_valid, main/skid load enables); data registers stay in pipe_skid_reg.

Verification
REQ-031 Reset: assert rst mid-cycle with state FULL -> out_valid=0, out_data=RESET_VALUE at once; after release in_ready=1.
REQ-032 Streaming, SKID=1: send 0x1..0x10 with out_ready=1 -> 16 outputs in order on 16 consecutive cycles, first one cycle after first acceptance.
REQ-033 Backpressure: out_ready=0, send 0xA,0xB,0xC -> 0xA,0xB accepted, in_ready=0 thereafter, out_data stable 0xA; release -> 0xA,0xB,0xC in order.
REQ-034 Flush with state FULL and in_valid=1 (0xD) -> next cycle out_valid=0, in_ready=1, 0xD never appears.
REQ-035 SKID=0 streaming with out_ready=1 -> one transfer every 2 cycles, in_ready never 1 while out_valid=1.
REQ-036 Random valid/ready (10k cycles, both SKID values) -> scoreboard matches, REQ-024 stability assertion never fires.
